// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants, default boundaries and FSM encoding for the scene controller
package vga_pkg;

    localparam int CFG_DATA_W   = 10;
    localparam int CFG_NUM_REGS = 8;

    localparam logic [CFG_DATA_W-1:0] DEF_Y0 = 10'd135;
    localparam logic [CFG_DATA_W-1:0] DEF_Y1 = 10'd205;
    localparam logic [CFG_DATA_W-1:0] DEF_Y2 = 10'd217;
    localparam logic [CFG_DATA_W-1:0] DEF_Y3 = 10'd305;
    localparam logic [CFG_DATA_W-1:0] DEF_Y4 = 10'd310;
    localparam logic [CFG_DATA_W-1:0] DEF_Y5 = 10'd414;
    localparam logic [CFG_DATA_W-1:0] DEF_X0 = 10'd324;
    localparam logic [CFG_DATA_W-1:0] DEF_X1 = 10'd604;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_COPY  = 2'd2,
        ST_DONE  = 2'd3
    } scene_state_t;

    // Registers beyond the standard eight have no defined boundary and reset to 0.
    function automatic logic [CFG_DATA_W-1:0] def_value(input int idx);
        case (idx)
            0:       def_value = DEF_Y0;
            1:       def_value = DEF_Y1;
            2:       def_value = DEF_Y2;
            3:       def_value = DEF_Y3;
            4:       def_value = DEF_Y4;
            5:       def_value = DEF_Y5;
            6:       def_value = DEF_X0;
            7:       def_value = DEF_X1;
            default: def_value = '0;
        endcase
    endfunction

endpackage

// File: rtl/vga_scene_ctrl_if.sv
// rtl/vga_scene_ctrl_if.sv - host write and commit handshake bundle
interface vga_scene_ctrl_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 10
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              commit_req;
    logic              commit_pending;
    logic              commit_done;

    modport master (
        output wr_valid, wr_addr, wr_data, commit_req,
        input  wr_ready, commit_pending, commit_done
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, commit_req,
        output wr_ready, commit_pending, commit_done
    );
endinterface

// File: rtl/vga_cfg_regfile.sv
// rtl/vga_cfg_regfile.sv - shadow and active boundary arrays with atomic copy strobe
module vga_cfg_regfile
    import vga_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 10,
    parameter int ADDR_W   = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic                         copy,
    output logic [NUM_REGS*DATA_W-1:0]   cfg_active
);

    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [DATA_W-1:0] active [NUM_REGS];

    // An address with no matching index simply never hits, so out-of-range writes drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= DATA_W'(def_value(i));
                active[i] <= DATA_W'(def_value(i));
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we && waddr == ADDR_W'(i))
                    shadow[i] <= wdata;
                if (copy)
                    active[i] <= shadow[i];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign cfg_active[g*DATA_W +: DATA_W] = active[g];
        end
    endgenerate

endmodule

// File: rtl/vga_scene_ctrl.sv
// rtl/vga_scene_ctrl.sv - frame-synchronous boundary configuration controller
// Optional FRAME_CNT_EN adds the frame_cnt output counting frame_start pulses.
module vga_scene_ctrl
    import vga_pkg::*;
#(
    parameter int NUM_REGS = CFG_NUM_REGS,
    parameter int DATA_W   = CFG_DATA_W,
    parameter int ADDR_W   = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        frame_start,
    vga_scene_ctrl_if.slave             bus,
    output logic [NUM_REGS*DATA_W-1:0]  cfg_active,
    output logic [7:0]                  cfg_gen
`ifdef FRAME_CNT_EN
    ,
    output logic [15:0]                 frame_cnt
`endif
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ARMED = ST_ARMED;
    localparam logic [1:0] S_COPY  = ST_COPY;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0] state;
    logic       wr_fire;

    assign bus.wr_ready       = (state == S_IDLE);
    assign bus.commit_pending = (state == S_ARMED) || (state == S_COPY);
    assign bus.commit_done    = (state == S_DONE);
    assign wr_fire            = bus.wr_valid && bus.wr_ready;

    // frame_start is only looked at in ARMED, so a commit requested on a
    // frame_start cycle waits a whole frame rather than copying mid-frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cfg_gen <= 8'd0;
        end else begin
            case (state)
                S_IDLE:  if (bus.commit_req) state <= S_ARMED;
                S_ARMED: if (frame_start)    state <= S_COPY;
                S_COPY: begin
                    state   <= S_DONE;
                    cfg_gen <= cfg_gen + 8'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    vga_cfg_regfile #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W)
    ) u_regfile (
        .clk        (clk),
        .reset_n    (reset_n),
        .we         (wr_fire),
        .waddr      (bus.wr_addr),
        .wdata      (bus.wr_data),
        .copy       (state == S_COPY),
        .cfg_active (cfg_active)
    );

`ifdef FRAME_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            frame_cnt <= 16'd0;
        else if (frame_start)
            frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_scene_ctrl.sv
// tb/tb_vga_scene_ctrl.sv - table-driven and sequence checks for vga_scene_ctrl
module tb_vga_scene_ctrl;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic [79:0] cfg_active;
    logic [7:0]  cfg_gen;
    logic [59:0] cfg_active6;
    logic [7:0]  cfg_gen6;
`ifdef FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic [15:0] frame_cnt6;
`endif

    always #10 clk = ~clk;

    vga_scene_ctrl_if #(.ADDR_W(3), .DATA_W(10)) bus ();
    vga_scene_ctrl_if #(.ADDR_W(3), .DATA_W(10)) bus6 ();

    vga_scene_ctrl #(.NUM_REGS(8), .DATA_W(10), .ADDR_W(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .bus         (bus.slave),
        .cfg_active  (cfg_active),
        .cfg_gen     (cfg_gen)
`ifdef FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    vga_scene_ctrl #(.NUM_REGS(6), .DATA_W(10), .ADDR_W(3)) dut6 (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .bus         (bus6.slave),
        .cfg_active  (cfg_active6),
        .cfg_gen     (cfg_gen6)
`ifdef FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt6)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    logic [9:0] exp_regs [8];

    function automatic logic [79:0] packed_exp();
        logic [79:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*10 +: 10] = exp_regs[i];
        return r;
    endfunction

    task automatic bus_idle();
        bus.wr_valid    = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.commit_req  = 1'b0;
        bus6.wr_valid   = 1'b0;
        bus6.wr_addr    = '0;
        bus6.wr_data    = '0;
        bus6.commit_req = 1'b0;
        frame_start     = 1'b0;
    endtask

    typedef struct {
        logic       wv;
        logic [2:0] wa;
        logic [9:0] wd;
        logic       cr;
        logic       fs;
        logic       e_ready;
        logic       e_pend;
        logic       e_done;
        logic [7:0] e_gen;
        int         idx;
        logic [9:0] e_val;
    } vec_t;

    vec_t vecs [14];

    logic [79:0] reset_vec;
    logic [59:0] reset_vec6;
    int          done_cnt;

    initial begin
        reset_vec  = {10'd604, 10'd324, 10'd414, 10'd310, 10'd305, 10'd217, 10'd205, 10'd135};
        reset_vec6 = {10'd414, 10'd310, 10'd305, 10'd217, 10'd205, 10'd135};
        exp_regs   = '{10'd135, 10'd205, 10'd217, 10'd305, 10'd310, 10'd414, 10'd324, 10'd604};

        //           wv wa    wd       cr fs  rdy pnd dn gen  idx val
        vecs[0]  = '{1, 3'd1, 10'd180, 0, 0,  1,  0,  0, 8'd0, 1, 10'd205};
        vecs[1]  = '{0, 3'd0, 10'd0,   1, 0,  0,  1,  0, 8'd0, 1, 10'd205};
        vecs[2]  = '{0, 3'd0, 10'd0,   0, 0,  0,  1,  0, 8'd0, 1, 10'd205};
        vecs[3]  = '{0, 3'd0, 10'd0,   0, 1,  0,  1,  0, 8'd0, 1, 10'd205};
        vecs[4]  = '{0, 3'd0, 10'd0,   0, 0,  0,  0,  1, 8'd1, 1, 10'd180};
        vecs[5]  = '{0, 3'd0, 10'd0,   0, 0,  1,  0,  0, 8'd1, 1, 10'd180};
        vecs[6]  = '{0, 3'd0, 10'd0,   1, 1,  0,  1,  0, 8'd1, 1, 10'd180};
        vecs[7]  = '{0, 3'd0, 10'd0,   0, 1,  0,  1,  0, 8'd1, 1, 10'd180};
        vecs[8]  = '{0, 3'd0, 10'd0,   1, 0,  0,  0,  1, 8'd2, 1, 10'd180};
        vecs[9]  = '{0, 3'd0, 10'd0,   0, 0,  1,  0,  0, 8'd2, 1, 10'd180};
        vecs[10] = '{1, 3'd7, 10'd500, 1, 0,  0,  1,  0, 8'd2, 7, 10'd604};
        vecs[11] = '{0, 3'd0, 10'd0,   0, 1,  0,  1,  0, 8'd2, 7, 10'd604};
        vecs[12] = '{0, 3'd0, 10'd0,   0, 0,  0,  0,  1, 8'd3, 7, 10'd500};
        vecs[13] = '{0, 3'd0, 10'd0,   0, 0,  1,  0,  0, 8'd3, 7, 10'd500};

        bus_idle();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("reset_cfg_active", cfg_active, reset_vec);
        check("reset_cfg_gen", 80'(cfg_gen), 80'd0);
        check("reset_wr_ready", 80'(bus.wr_ready), 80'd1);
        check("reset_commit_pending", 80'(bus.commit_pending), 80'd0);
        check("reset_commit_done", 80'(bus.commit_done), 80'd0);
        check("reset6_cfg_active", 80'(cfg_active6), 80'(reset_vec6));

        for (int k = 0; k < 14; k++) begin
            bus.wr_valid   = vecs[k].wv;
            bus.wr_addr    = vecs[k].wa;
            bus.wr_data    = vecs[k].wd;
            bus.commit_req = vecs[k].cr;
            frame_start    = vecs[k].fs;
            @(negedge clk);
            check($sformatf("vec%0d_wr_ready", k), 80'(bus.wr_ready), 80'(vecs[k].e_ready));
            check($sformatf("vec%0d_pending", k), 80'(bus.commit_pending), 80'(vecs[k].e_pend));
            check($sformatf("vec%0d_done", k), 80'(bus.commit_done), 80'(vecs[k].e_done));
            check($sformatf("vec%0d_gen", k), 80'(cfg_gen), 80'(vecs[k].e_gen));
            check($sformatf("vec%0d_reg%0d", k, vecs[k].idx),
                  80'(cfg_active[vecs[k].idx*10 +: 10]), 80'(vecs[k].e_val));
        end
        bus_idle();
        exp_regs[1] = 10'd180;
        exp_regs[7] = 10'd500;
        check("table_full_active", cfg_active, packed_exp());

        // Write, commit, then hammer the port while ARMED before a late frame_start.
        bus.wr_valid = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 10'd100;
        @(negedge clk);
        bus.wr_valid = 1'b0; bus.commit_req = 1'b1;
        @(negedge clk);
        bus.commit_req = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 10'd999;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("armed_wr_ready_c%0d", c), 80'(bus.wr_ready), 80'd0);
        end
        bus.wr_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("armed_still_pending", 80'(bus.commit_pending), 80'd1);
        check("armed_active_unchanged", cfg_active, packed_exp());
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("copy_edge1_reg0_old", 80'(cfg_active[9:0]), 80'd135);
        done_cnt = 0;
        @(negedge clk);
        exp_regs[0] = 10'd100;
        check("copy_edge2_active", cfg_active, packed_exp());
        check("copy_edge2_gen", 80'(cfg_gen), 80'd4);
        for (int c = 0; c < 4; c++) begin
            if (bus.commit_done) done_cnt++;
            @(negedge clk);
        end
        check("commit_done_pulses", 80'(done_cnt), 80'd1);

        // Reset asserted while ARMED drops the commit immediately.
        bus.commit_req = 1'b1;
        @(negedge clk);
        bus.commit_req = 1'b0;
        check("pre_reset_armed", 80'(bus.commit_pending), 80'd1);
        #5 reset_n = 1'b0;
        #1;
        check("async_reset_active", cfg_active, reset_vec);
        check("async_reset_gen", 80'(cfg_gen), 80'd0);
        check("async_reset_ready", 80'(bus.wr_ready), 80'd1);
        check("async_reset_pending", 80'(bus.commit_pending), 80'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (4) @(negedge clk);
        check("post_reset_no_copy_gen", 80'(cfg_gen), 80'd0);
        check("post_reset_no_copy_active", cfg_active, reset_vec);
        check("post_reset_idle", 80'(bus.wr_ready), 80'd1);

        // Six-register build: address 7 handshakes but lands nowhere.
        bus6.wr_valid = 1'b1; bus6.wr_addr = 3'd7; bus6.wr_data = 10'd50;
        bus6.commit_req = 1'b1;
        #1;
        check("n6_wr_ready", 80'(bus6.wr_ready), 80'd1);
        @(negedge clk);
        bus6.wr_valid = 1'b0; bus6.commit_req = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        check("n6_gen", 80'(cfg_gen6), 80'd1);
        check("n6_active_unchanged", 80'(cfg_active6), 80'(reset_vec6));

`ifdef FRAME_CNT_EN
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
            @(negedge clk);
        end
        check("frame_cnt", 80'(frame_cnt), 80'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
